pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
//------------------------------------------------------------------------------
// pc_fetch_unit
//
// Purpose:
//   Front end of the pipelined CPU. Holds the architectural fetch PC, walks
//   it forward by 4 as instruction memory accepts requests, and follows
//   branch/jump redirects. Each accepted request is remembered in a small
//   PC-tag queue, so every in-order response can be paired with the address
//   that produced it. The {pc, instruction} pairs are buffered in a response
//   FIFO and handed to the IF/ID stage through a valid/ready handshake.
//
//   Requests are credit-gated: requests in flight plus FIFO entries never
//   exceed BUF_DEPTH. A response therefore always has a free FIFO slot, and
//   the memory side never needs backpressure on responses.
//
//   A redirect throws away everything younger than the new target. Responses
//   for requests already in flight still arrive, so they are counted in
//   drop_cnt and swallowed in the FLUSH state before fetching resumes.
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            synchronous active-low reset
//   redirect_valid   branch/jump taken, load redirect_pc
//   redirect_pc      redirect target
//   imem_req_valid   fetch request valid
//   imem_req_ready   instruction memory accepts the request
//   imem_addr        fetch address (always the current pc)
//   imem_resp_valid  instruction returned, in request order
//   imem_resp_data   returned instruction
//   if_valid         FIFO head valid towards IF/ID
//   if_ready         IF/ID accepts the head entry
//   if_pc            PC of the head instruction
//   if_instr         head instruction
//   misalign_err     sticky misaligned-redirect flag
//
// Build option:
//   PC_MISALIGN_CHECK_EN
//     defined   - a redirect whose target has bits [1:0] != 0 is ignored and
//                 misalign_err is set until reset.
//     undefined - the low two target bits are cleared on load and
//                 misalign_err is tied to 0.
//
// BUF_DEPTH must be a power of two and at least 2; the FIFO and tag-queue
// pointers rely on natural wrap-around.
//------------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int unsigned                  instruction_width = 32,
    parameter logic [instruction_width-1:0] RESET_PC          = 32'h0000_0000,
    parameter int unsigned                  BUF_DEPTH         = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         redirect_valid,
    input  logic [instruction_width-1:0] redirect_pc,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [instruction_width-1:0] imem_addr,
    input  logic                         imem_resp_valid,
    input  logic [instruction_width-1:0] imem_resp_data,
    output logic                         if_valid,
    input  logic                         if_ready,
    output logic [instruction_width-1:0] if_pc,
    output logic [instruction_width-1:0] if_instr,
    output logic                         misalign_err
);

    localparam int unsigned W     = instruction_width;
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // One bit wider than the counters, so the credit sum cannot overflow.
    localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state;
    logic [W-1:0]     pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;

    // PC-tag queue: addresses of accepted requests that still await a response.
    logic [W-1:0]     tag_mem [BUF_DEPTH];
    logic [PTR_W-1:0] tag_wr_ptr;
    logic [PTR_W-1:0] tag_rd_ptr;

    // Response FIFO towards IF/ID.
    logic [W-1:0]     fifo_pc_mem    [BUF_DEPTH];
    logic [W-1:0]     fifo_instr_mem [BUF_DEPTH];
    logic [PTR_W-1:0] fifo_wr_ptr;
    logic [PTR_W-1:0] fifo_rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    logic             redirect_ok;
    logic             redirect_take;
    logic [W-1:0]     redirect_target;
    logic [CNT_W:0]   occupancy;
    logic             credit_ok;
    logic             req_fire;
    logic             resp_acc;
    logic             fifo_push;
    logic             fifo_pop;
    logic [CNT_W-1:0] inflight_next;

    //--------------------------------------------------------------------------
    // Redirect qualification. With the alignment check built in, a misaligned
    // target is refused outright and only raises the sticky error flag.
    // Without the check, the target is forced onto a word boundary.
    //--------------------------------------------------------------------------
`ifdef PC_MISALIGN_CHECK_EN
    assign redirect_ok     = (redirect_pc[1:0] == 2'b00);
    assign redirect_target = redirect_pc;

    // Sticky until reset. Misaligned targets during BOOT are ignored, like
    // every other redirect in BOOT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && (state != BOOT) && !redirect_ok) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign redirect_ok     = 1'b1;
    assign redirect_target = redirect_pc & ~W'(3);
    assign misalign_err    = 1'b0;
`endif

    assign redirect_take = redirect_valid && (state != BOOT) && redirect_ok;

    //--------------------------------------------------------------------------
    // Request side. The credit sum can only stay the same or shrink while a
    // request waits: a response just moves one unit from outstanding into
    // the FIFO. A raised request therefore stays up, with a stable address,
    // until memory takes it. The only exception is a redirect, which
    // withdraws the request in its own cycle.
    //--------------------------------------------------------------------------
    assign occupancy      = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok      = (occupancy < DEPTH_LIMIT);
    assign imem_req_valid = (state == FETCH) && credit_ok && !redirect_take;
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is not counted, so the counters
    // can never underflow.
    assign resp_acc  = imem_resp_valid && (outstanding != '0);
    assign fifo_push = (state == FETCH) && resp_acc && !redirect_take;

    // A redirect flushes the FIFO anyway, so a same-cycle pop has no extra
    // effect on the pointers. IF/ID still treats that head as consumed.
    assign fifo_pop  = if_valid && if_ready && !redirect_take;

    // Requests still in flight after this edge. In a redirect cycle this is
    // also the number of stale responses that must be dropped.
    assign inflight_next = outstanding + CNT_W'(req_fire) - CNT_W'(resp_acc);

    assign if_valid = (fifo_count != '0);
    assign if_pc    = fifo_pc_mem[fifo_rd_ptr];
    assign if_instr = fifo_instr_mem[fifo_rd_ptr];

    //--------------------------------------------------------------------------
    // Control FSM. BOOT waits for one idle cycle after reset. FETCH walks the
    // pc forward on every accepted request. FLUSH swallows responses that
    // belong to requests issued before a redirect. In FLUSH, drop_cnt and
    // outstanding always hold the same value, because the redirect also
    // emptied the tag queue.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= inflight_next;
            case (state)
                BOOT: begin
                    state <= FETCH;
                end
                FETCH, FLUSH: begin
                    if (redirect_take) begin
                        pc       <= redirect_target;
                        drop_cnt <= inflight_next;
                        state    <= (inflight_next != '0) ? FLUSH : FETCH;
                    end else if (state == FETCH) begin
                        if (req_fire) begin
                            pc <= pc + W'(4);
                        end
                    end else if (resp_acc) begin
                        drop_cnt <= drop_cnt - CNT_W'(1);
                        if (drop_cnt == CNT_W'(1)) begin
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // PC-tag queue. It is written with the pc of every accepted request and
    // read on every response that lands in the FIFO. It never holds more
    // than BUF_DEPTH entries, because the credit check limits outstanding
    // requests. A redirect drops all of its entries.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
        end else if (redirect_take) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
        end else begin
            if (req_fire) begin
                tag_mem[tag_wr_ptr] <= pc;
                tag_wr_ptr          <= tag_wr_ptr + PTR_W'(1);
            end
            if (fifo_push) begin
                tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
            end
        end
    end

    //--------------------------------------------------------------------------
    // Response FIFO. The head entry is read straight from registers, so a
    // response becomes visible on if_pc/if_instr one cycle after it arrives.
    // The storage is cleared on reset so that if_pc and if_instr read 0 out
    // of reset. Push and pop in the same cycle are allowed at any fill
    // level, including full.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifo_pc_mem[i]    <= '0;
                fifo_instr_mem[i] <= '0;
            end
        end else if (redirect_take) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
        end else begin
            if (fifo_push) begin
                fifo_pc_mem[fifo_wr_ptr]    <= tag_mem[tag_rd_ptr];
                fifo_instr_mem[fifo_wr_ptr] <= imem_resp_data;
                fifo_wr_ptr                 <= fifo_wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Purpose:
//   Self-checking bench for pc_fetch_unit. It models an in-order instruction
//   memory and uses a transaction-level reference: a queue of requests in
//   flight (the oldest stale_count of them predate the last redirect), a
//   queue of {pc, instr} pairs owed to IF/ID, and the expected next fetch
//   address. Every cycle it checks the request valid, the fetch address,
//   if_valid, misalign_err, and the delivered pairs against that model.
//
//   The PC_MISALIGN_CHECK_EN macro selects the matching redirect rule in the
//   model.
//------------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          ready_cycle;
    } imem_txn_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign_err;

    imem_txn_t   inflight[$];
    fetch_t      expq[$];
    int          stale_count;
    logic [31:0] model_pc;
    logic        model_err;
    int          cycle_no;

    int          check_count;
    int          error_count;

    pc_fetch_unit #(
        .instruction_width (32),
        .RESET_PC          (RESET_PC),
        .BUF_DEPTH         (BUF_DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .misalign_err    (misalign_err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     tag, actual, expected, cycle_no);
        end
    endtask

    // Hold reset for a few edges and check the reset values. Then release
    // reset and check that the BOOT cycle stays idle. Instruction memory is
    // reset together with the DUT, so the model forgets everything in flight.
    task automatic resetDut();
        @(negedge clk);
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if_ready        = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'd0);
        checkOutput("rst_if_instr", if_instr, 32'd0);
        checkOutput("rst_misalign", 32'(misalign_err), 32'd0);
        inflight.delete();
        expq.delete();
        stale_count = 0;
        model_pc    = RESET_PC;
        model_err   = 1'b0;
        rst_n       = 1'b1;
        #1;
        checkOutput("boot_req_valid", 32'(imem_req_valid), 32'd0);
    endtask

    // Run a number of cycles with the given percent probabilities for
    // if_ready, imem_req_ready, response return and random redirects. If
    // force_redirect is set, the first cycle redirects to force_target.
    task automatic applyStimulus(input int cycles, input int p_if_ready,
                                 input int p_req_ready, input int p_resp,
                                 input int p_redirect, input bit force_redirect,
                                 input logic [31:0] force_target);
        bit          redir;
        bit          take;
        bit          aligned;
        bit          resp_now;
        bit          fire;
        bit          exp_req_valid;
        logic [31:0] tgt;
        logic [31:0] eff_tgt;
        imem_txn_t   txn;
        fetch_t      head;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            cycle_no++;

            if_ready       = ($urandom_range(99) < p_if_ready);
            imem_req_ready = ($urandom_range(99) < p_req_ready);
            resp_now       = (inflight.size() != 0) &&
                             (inflight[0].ready_cycle <= cycle_no) &&
                             ($urandom_range(99) < p_resp);
            imem_resp_valid = resp_now;
            imem_resp_data  = resp_now ? inflight[0].data : $urandom;

            tgt = $urandom;
            if ($urandom_range(9) == 0) begin
                tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000F);
            end
            redir = ($urandom_range(99) < p_redirect);
            if (force_redirect && (c == 0)) begin
                redir = 1'b1;
                tgt   = force_target;
            end
            redirect_valid = redir;
            redirect_pc    = tgt;

`ifdef PC_MISALIGN_CHECK_EN
            aligned = (tgt[1:0] == 2'b00);
            eff_tgt = tgt;
`else
            aligned = 1'b1;
            eff_tgt = tgt & 32'hFFFF_FFFC;
`endif
            take = redir && aligned;

            #1;
            // Observable behaviour expected before this clock edge.
            exp_req_valid = !take && (stale_count == 0) &&
                            ((inflight.size() + expq.size()) < BUF_DEPTH);
            checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_req_valid));
            if (imem_req_valid === 1'b1) begin
                checkOutput("imem_addr", imem_addr, model_pc);
            end
            checkOutput("if_valid", 32'(if_valid), 32'(expq.size() != 0));
            checkOutput("misalign_err", 32'(misalign_err), 32'(model_err));
            if ((expq.size() != 0) && if_ready) begin
                head = expq.pop_front();
                checkOutput("if_pc", if_pc, head.pc);
                checkOutput("if_instr", if_instr, head.instr);
            end
            fire = (imem_req_valid === 1'b1) && imem_req_ready;

            // Effects of the coming clock edge on the reference model.
            if (resp_now) begin
                txn = inflight.pop_front();
                if (stale_count > 0) begin
                    stale_count--;
                end else if (!take) begin
                    expq.push_back('{pc: txn.addr, instr: txn.data});
                end
            end
            if (take) begin
                expq.delete();
                stale_count = inflight.size();
                model_pc    = eff_tgt;
            end else if (redir) begin
                model_err = 1'b1;
            end
            if (fire) begin
                inflight.push_back('{addr: imem_addr, data: $urandom,
                                     ready_cycle: cycle_no + 1});
                if (take) begin
                    stale_count++;
                end else begin
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    endtask

    // Directed scenarios first, then long randomized runs, including a reset
    // in the middle of traffic.
    initial begin
        check_count = 0;
        error_count = 0;
        cycle_no    = 0;
        rst_n       = 1'b0;

        $display("[TB] reset and free-running fetch");
        resetDut();
        applyStimulus(8, 100, 100, 100, 0, 1'b0, 32'h0);

        $display("[TB] IF/ID backpressure");
        applyStimulus(10, 0, 100, 100, 0, 1'b0, 32'h0);
        applyStimulus(8, 100, 100, 100, 0, 1'b0, 32'h0);

        $display("[TB] redirect with requests outstanding");
        applyStimulus(4, 100, 100, 0, 0, 1'b0, 32'h0);
        applyStimulus(1, 100, 100, 0, 0, 1'b1, 32'h0000_0100);
        applyStimulus(12, 100, 100, 100, 0, 1'b0, 32'h0);

        $display("[TB] memory not ready");
        applyStimulus(5, 100, 0, 100, 0, 1'b0, 32'h0);
        applyStimulus(6, 100, 100, 100, 0, 1'b0, 32'h0);

        $display("[TB] wrap at top of address space");
        applyStimulus(1, 100, 100, 100, 0, 1'b1, 32'hFFFF_FFFC);
        applyStimulus(8, 100, 100, 100, 0, 1'b0, 32'h0);

        $display("[TB] misaligned redirect");
        applyStimulus(1, 100, 100, 100, 0, 1'b1, 32'h0000_0102);
        applyStimulus(8, 100, 100, 100, 0, 1'b0, 32'h0);

        $display("[TB] randomized traffic");
        applyStimulus(3000, 70, 70, 60, 3, 1'b0, 32'h0);

        $display("[TB] reset mid-operation and more random traffic");
        resetDut();
        applyStimulus(1500, 50, 50, 50, 5, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
